// File: rtl/gol_avalon_cmd_master.sv
// gol_avalon_cmd_master
//
// Avalon-MM master for the PIO-class slaves in the soc_system fabric. Fabric
// logic issues single read or write commands on a valid/ready port. Each command
// becomes one Avalon transfer, and each transfer returns exactly one response
// pulse. Only one transaction is ever outstanding.
//
// Optional build macro: GOL_AVM_TIMEOUT_EN
//   Defined   : a transfer that is stalled by waitrequest for TIMEOUT_CYCLES
//               consecutive cycles is aborted and answered with rsp_error=1.
//   Undefined : the block waits for waitrequest indefinitely, and rsp_error
//               is always 0.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_write               1 = write, 0 = read
//   cmd_address             target word address
//   cmd_writedata           write data
//   rsp_valid               one-cycle response pulse
//   rsp_readdata            read result (0 for writes and aborts); holds until
//                           the next response
//   rsp_error               1 = transfer aborted by timeout
//   avm_*                   Avalon-MM master interface (read latency 0)
//
// State table
//   state  | meaning
//   IDLE   | ready for a command, all bus strobes inactive
//   ACCESS | strobes asserted, waiting for a cycle with waitrequest low
//   RESP   | rsp_valid is high for this single cycle

module gol_avalon_cmd_master #(
    parameter int ADDR_W         = 2,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_writedata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_readdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("gol_avalon_cmd_master: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;

    // cmd_ready must stay low throughout reset, even though the state register
    // already holds IDLE. This flag goes high on the first clock after release.
    logic out_of_reset;

    assign cmd_ready = out_of_reset && (state == IDLE);

    logic timeout_hit;

`ifdef GOL_AVM_TIMEOUT_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] stall_cnt;

    // The counter shows how many stalled ACCESS cycles came before this one.
    // When it reaches STALL_LAST, the current cycle is the TIMEOUT_CYCLES-th.
    assign timeout_hit = avm_waitrequest && (stall_cnt == STALL_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            out_of_reset   <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_readdata   <= '0;
            rsp_error      <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            avm_writedata  <= '0;
`ifdef GOL_AVM_TIMEOUT_EN
            stall_cnt      <= '0;
`endif
        end else begin
            out_of_reset <= 1'b1;
            rsp_valid    <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        avm_address    <= cmd_address;
                        avm_writedata  <= cmd_writedata;
                        avm_chipselect <= 1'b1;
                        avm_write_n    <= ~cmd_write;
                        avm_read_n     <= cmd_write;
`ifdef GOL_AVM_TIMEOUT_EN
                        stall_cnt      <= '0;
`endif
                        state          <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!avm_waitrequest) begin
                        // avm_read_n low means this transfer is a read.
                        // Address and writedata keep their values. Only the
                        // strobes go back to inactive.
                        rsp_readdata   <= avm_read_n ? '0 : avm_readdata;
                        rsp_error      <= 1'b0;
                        rsp_valid      <= 1'b1;
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        avm_read_n     <= 1'b1;
                        state          <= RESP;
                    end else if (timeout_hit) begin
                        rsp_readdata   <= '0;
                        rsp_error      <= 1'b1;
                        rsp_valid      <= 1'b1;
                        avm_chipselect <= 1'b0;
                        avm_write_n    <= 1'b1;
                        avm_read_n     <= 1'b1;
                        state          <= RESP;
                    end else begin
`ifdef GOL_AVM_TIMEOUT_EN
                        stall_cnt <= stall_cnt + 16'd1;
`endif
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gol_avalon_cmd_master.sv
module tb_gol_avalon_cmd_master;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int TO     = 8;

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    gol_avalon_cmd_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_readdata(rsp_readdata),
        .rsp_error(rsp_error),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=rsp_valid expected=none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_readdata", rsp_readdata, mon_e.rd);
                chk("rsp_error", {31'b0, rsp_error}, {31'b0, mon_e.err});
                chk("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Wait, with a bound, until a falling edge where cmd_ready is high.
    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (cmd_ready === 1'b1);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%0b expected=1", cmd_ready);
        end
    endtask

    // One command with `waits` stalled ACCESS cycles. During the stalls the
    // slave drives junk readdata, so a capture outside the completing cycle shows up.
    task automatic do_cmd(input logic wr, input logic [1:0] a, input logic [31:0] d,
                          input logic [31:0] rdv, input int waits);
        bit ok;
        int t;
        wait_ready(ok);
        if (!ok) return;
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = a;
        cmd_writedata = d;
        t = cyc;
        sb.push_back('{(wr ? 32'h0 : rdv), 1'b0, t + 2 + waits});
        for (int k = 1; k <= waits + 1; k++) begin
            @(negedge clk);
            cmd_valid     = 1'b0;
            cmd_address   = ~a;
            cmd_writedata = ~d;
            chk("chipselect", {31'b0, avm_chipselect}, 32'h1);
            chk("write_n", {31'b0, avm_write_n}, {31'b0, ~wr});
            chk("read_n", {31'b0, avm_read_n}, {31'b0, wr});
            chk("address", {30'b0, avm_address}, {30'b0, a});
            if (wr) chk("writedata", avm_writedata, d);
            chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'h0);
            avm_waitrequest = (k <= waits);
            avm_readdata    = (k <= waits) ? (32'hBAD0_0000 + k) : rdv;
        end
        @(negedge clk);
        chk("cs_released", {31'b0, avm_chipselect}, 32'h0);
        chk("write_n_released", {31'b0, avm_write_n}, 32'h1);
        chk("read_n_released", {31'b0, avm_read_n}, 32'h1);
        chk("address_kept", {30'b0, avm_address}, {30'b0, a});
        chk("cmd_ready_resp", {31'b0, cmd_ready}, 32'h0);
        avm_waitrequest = 1'b0;
    endtask

    initial begin
        bit ok;
        int t;

        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_address     = '0;
        cmd_writedata   = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h0);
        chk("rst_cs", {31'b0, avm_chipselect}, 32'h0);
        chk("rst_write_n", {31'b0, avm_write_n}, 32'h1);
        chk("rst_read_n", {31'b0, avm_read_n}, 32'h1);
        chk("rst_address", {30'b0, avm_address}, 32'h0);
        chk("rst_writedata", avm_writedata, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_readdata", rsp_readdata, 32'h0);
        chk("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, cmd_ready}, 32'h1);

        do_cmd(1'b1, 2'd0, 32'h0000_0001, 32'h0, 0);
        do_cmd(1'b0, 2'd0, 32'h0, 32'h0000_0001, 0);
        do_cmd(1'b1, 2'd3, 32'hA5A5_5A5A, 32'h0, 1);
        do_cmd(1'b0, 2'd2, 32'h0, 32'hDEAD_BEEF, 3);
        repeat (3) @(negedge clk);
        chk("rsp_readdata_hold", rsp_readdata, 32'hDEAD_BEEF);

        // Back-to-back commands with cmd_valid held high.
        wait_ready(ok);
        if (ok) begin
            cmd_valid     = 1'b1;
            cmd_write     = 1'b1;
            cmd_address   = 2'd1;
            cmd_writedata = 32'h1234_5678;
            t = cyc;
            sb.push_back('{32'h0, 1'b0, t + 2});
            @(negedge clk);
            cmd_write     = 1'b0;
            cmd_address   = 2'd3;
            avm_readdata  = 32'h0000_0055;
            chk("b2b_ready_t1", {31'b0, cmd_ready}, 32'h0);
            chk("b2b_cs_t1", {31'b0, avm_chipselect}, 32'h1);
            chk("b2b_write_n_t1", {31'b0, avm_write_n}, 32'h0);
            chk("b2b_addr_t1", {30'b0, avm_address}, 32'h1);
            chk("b2b_wdata_t1", avm_writedata, 32'h1234_5678);
            @(negedge clk);
            sb.push_back('{32'h0000_0055, 1'b0, t + 5});
            chk("b2b_ready_t2", {31'b0, cmd_ready}, 32'h0);
            chk("b2b_cs_t2", {31'b0, avm_chipselect}, 32'h0);
            @(negedge clk);
            chk("b2b_ready_t3", {31'b0, cmd_ready}, 32'h1);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("b2b_cs_t4", {31'b0, avm_chipselect}, 32'h1);
            chk("b2b_read_n_t4", {31'b0, avm_read_n}, 32'h0);
            chk("b2b_write_n_t4", {31'b0, avm_write_n}, 32'h1);
            chk("b2b_addr_t4", {30'b0, avm_address}, 32'h3);
            @(negedge clk);
            chk("b2b_cs_t5", {31'b0, avm_chipselect}, 32'h0);
        end

        // Reset in the middle of a stalled write: the transaction is dropped.
        wait_ready(ok);
        if (ok) begin
            cmd_valid       = 1'b1;
            cmd_write       = 1'b1;
            cmd_address     = 2'd2;
            cmd_writedata   = 32'h0000_CAFE;
            avm_waitrequest = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("mid_cs_before", {31'b0, avm_chipselect}, 32'h1);
            reset_n = 1'b0;
            #1;
            chk("mid_rst_cs", {31'b0, avm_chipselect}, 32'h0);
            chk("mid_rst_write_n", {31'b0, avm_write_n}, 32'h1);
            chk("mid_rst_ready", {31'b0, cmd_ready}, 32'h0);
            chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
            chk("mid_rst_wdata", avm_writedata, 32'h0);
            repeat (3) @(negedge clk);
            reset_n         = 1'b1;
            avm_waitrequest = 1'b0;
            @(negedge clk);
            chk("mid_ready_after", {31'b0, cmd_ready}, 32'h1);
        end
        do_cmd(1'b0, 2'd1, 32'h0, 32'h0000_0042, 0);

        // Slave stuck in waitrequest.
        wait_ready(ok);
        if (ok) begin
            cmd_valid       = 1'b1;
            cmd_write       = 1'b0;
            cmd_address     = 2'd1;
            avm_waitrequest = 1'b1;
            avm_readdata    = 32'hFFFF_FFFF;
            t = cyc;
`ifdef GOL_AVM_TIMEOUT_EN
            sb.push_back('{32'h0, 1'b1, t + TO + 1});
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                chk("to_cs", {31'b0, avm_chipselect}, 32'h1);
                chk("to_read_n", {31'b0, avm_read_n}, 32'h0);
            end
            @(negedge clk);
            chk("to_cs_released", {31'b0, avm_chipselect}, 32'h0);
            chk("to_read_n_released", {31'b0, avm_read_n}, 32'h1);
            avm_waitrequest = 1'b0;
`else
            repeat (100) begin
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            chk("stuck_cs", {31'b0, avm_chipselect}, 32'h1);
            chk("stuck_read_n", {31'b0, avm_read_n}, 32'h0);
            chk("stuck_ready", {31'b0, cmd_ready}, 32'h0);
            avm_readdata    = 32'h0000_0077;
            avm_waitrequest = 1'b0;
            sb.push_back('{32'h0000_0077, 1'b0, cyc + 1});
            @(negedge clk);
`endif
            @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_rsp actual=%0d expected=0 outstanding", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
